ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Single-port RAM arbiter between the data-side coherence controller and the per-core instruction caches. It owns ramREN/ramWEN/ramaddr/ramstore. Only one word transfer is outstanding at a time. Data has priority, the instruction caches are served round-robin, and a run counter bounds instruction starvation. It sits between memory control / the icaches and the RAM model.

Parameters:
CPUS, 2, number of instruction requesters (>=2)
DRUN_MAX, 4, max consecutive data grants while any iREN pending (1..15)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
dREN  in  1  data read request from coherence controller
dWEN  in  1  data write request; wins over dREN if both high
daddr  in  32  data word address
dstore  in  32  data write word
dlock  in  1  keep data ownership for the next word (two-word block sequences)
dwait  out  1  low for exactly the ACCESS cycle of a data transfer
dload  out  32  RAM read word to data side
iREN  in  CPUS  instruction read requests
iaddr  in  CPUS*32  instruction addresses, core k at [32k+31:32k]
iwait  out  CPUS  per-core wait; low only in that core's ACCESS cycle
iload  out  CPUS*32  RAM read word, driven to granted core only
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
ram_err  out  1  sticky, set on ERROR

Behaviour:
- Reset (RST high, asynchronous): state IDLE, rr pointer = CPUS-1, drun = 0, ram_err = 0. All outputs: enables 0, addr/store/load 0, dwait=1, iwait all 1.
- FSM states: IDLE, DGRANT, IGRANT. State, owner index, rr pointer and drun are registered. RAM outputs are combinational from state/owner.
- IDLE arbitration:
  - if (dREN|dWEN) and not (iREN!=0 and drun==DRUN_MAX): go to DGRANT;
  - else if iREN!=0: go to IGRANT, owner = first set bit after rr pointer, circular.
  - Grant-to-enable latency is 1 cycle: a request seen in IDLE at cycle n gives ramREN/ramWEN at n+1.
- DGRANT:
  - ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN; ramstore=dstore when writing, else 0; dload=ramload.
  - On ramstate==ACCESS: dwait=0 that cycle.
  - If dlock=1 and (dREN|dWEN) remain high, stay in DGRANT (no arbitration gap). Otherwise return to IDLE.
  - drun increments (saturating at DRUN_MAX) on each completion while iREN!=0. drun clears to 0 whenever iREN==0.
- IGRANT:
  - ramaddr=iaddr[owner]; ramREN=1; iload[owner]=ramload, other lanes 0.
  - On ACCESS: iwait[owner]=0, rr pointer=owner, drun=0, return to IDLE.
  - An instruction grant is never extended; back-to-back same-core fetches re-arbitrate.
- Withdrawal: if the owner's request drops before ACCESS, enables drop the same cycle (gated by the request), no wait pulse is issued, and the FSM returns to IDLE next cycle.
- ERROR: treated as termination. No wait pulse, ram_err set (held until reset), FSM returns to IDLE. The requester re-requests if desired.
- FREE/BUSY: hold the grant and all drives stable.
- Idle cycle: at least one IDLE cycle between different owners. No IDLE cycle is inserted during a dlock chain.
- Non-owners always see wait=1 and load=0.
- Reset mid-transfer: enables go low immediately and no wait pulse is issued.

Test Plan:
- Single fetch: iREN=01, iaddr0=0x100, ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramREN high cycles 1-3, iwait[0] low only in cycle 3, iload0=0xDEADBEEF, back to IDLE.
- Priority + RR: dREN=1, iREN=11 all held, DRUN_MAX=4, RAM ACCESS every cycle -> grant order D,D,D,D,I0,D,D,D,D,I1; iwait never low for a non-owner.
- Locked pair: dWEN=1, dlock=1, daddr 0x200 then 0x204, dstore 0x11/0x22 -> two consecutive ramWEN transfers with no IDLE gap; iREN=01 is served only afterwards.
- Write wins: dREN=dWEN=1 -> ramWEN=1, ramREN=0, ramstore=dstore.
- Withdrawal / error: owner drops iREN during BUSY -> ramREN=0 same cycle, no iwait pulse. Later, ramstate=ERROR during DGRANT -> dwait stays 1, ram_err=1 until reset.
- Async reset asserted mid-DGRANT between clock edges -> ramWEN=0, dwait=1 immediately; after release, state IDLE and drun=0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Purpose : single-port RAM arbiter; data side has priority, icaches are served round-robin.
// Latency : a request seen in IDLE drives the RAM enables on the next cycle; one word is in flight at a time.
// Backpressure: requesters are held on wait=1 until the RAM reports ACCESS; FREE/BUSY hold the grant.
//
// Ports:
//   CLK, RST                 rising-edge clock, asynchronous active-high reset
//   dREN/dWEN/daddr/dstore   data-side read/write request, word address, write word
//   dlock                    keep data ownership for the following word (block pairs)
//   dwait/dload              data-side wait (low in the ACCESS cycle) and read word
//   iREN/iaddr               per-core instruction read request and address (core k at [32k+31:32k])
//   iwait/iload              per-core wait and read word; only the granted core sees activity
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate   RAM model interface
//   ram_err                  sticky error flag, set when the RAM answers ERROR
module ram_arbiter #(
    parameter int CPUS     = 2,
    parameter int DRUN_MAX = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [31:0]         daddr,
    input  logic [31:0]         dstore,
    input  logic                dlock,
    output logic                dwait,
    output logic [31:0]         dload,
    input  logic [CPUS-1:0]     iREN,
    input  logic [CPUS*32-1:0]  iaddr,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS*32-1:0]  iload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate,
    output logic                ram_err
);

    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [3:0] DRUN_LIM = 4'(DRUN_MAX);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DGRANT = 2'd1,
        S_IGRANT = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   owner, owner_nx;
    logic [OW-1:0]   rr, rr_nx;
    logic [3:0]      drun, drun_nx;
    logic            ram_err_nx;

    logic            d_req;
    logic            i_any;
    logic            i_req;
    logic [31:0]     iaddr_sel;
    logic [OW-1:0]   pick;
    logic            pick_vld;

    assign d_req = dREN | dWEN;
    assign i_any = |iREN;

    // Request and address of the core currently holding the instruction grant.
    always_comb begin
        i_req     = 1'b0;
        iaddr_sel = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (owner == OW'(k)) begin
                i_req     = iREN[k];
                iaddr_sel = iaddr[32*k +: 32];
            end
        end
    end

    // Round-robin pick: first requesting core strictly after the last served one,
    // wrapping around, so the last served core has the lowest priority.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= CPUS; i++) begin
            for (int k = 0; k < CPUS; k++) begin
                if (!pick_vld && iREN[k] && (k == ((int'(rr) + i) % CPUS))) begin
                    pick     = OW'(k);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            owner   <= '0;
            rr      <= OW'(CPUS - 1);
            drun    <= '0;
            ram_err <= 1'b0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            rr      <= rr_nx;
            drun    <= drun_nx;
            ram_err <= ram_err_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        rr_nx      = rr;
        drun_nx    = drun;
        ram_err_nx = ram_err;

        case (state)
            S_IDLE: begin
                // Data wins unless it has used up its run while instruction fetches wait.
                if (d_req && !(i_any && (drun == DRUN_LIM))) begin
                    state_nx = S_DGRANT;
                end else if (i_any) begin
                    state_nx = S_IGRANT;
                    owner_nx = pick;
                end
            end

            S_DGRANT: begin
                if (!d_req) begin
                    // Withdrawn before completion: enables already dropped, no wait pulse.
                    state_nx = S_IDLE;
                end else if (ramstate == RS_ACCESS) begin
                    if (i_any && (drun != DRUN_LIM)) begin
                        drun_nx = drun + 4'd1;
                    end
                    // A locked word keeps ownership with no arbitration gap.
                    if (!dlock) begin
                        state_nx = S_IDLE;
                    end
                end else if (ramstate == RS_ERROR) begin
                    ram_err_nx = 1'b1;
                    state_nx   = S_IDLE;
                end
            end

            S_IGRANT: begin
                if (!i_req) begin
                    state_nx = S_IDLE;
                end else if (ramstate == RS_ACCESS) begin
                    // Instruction grants are single-word; the served core becomes lowest priority.
                    rr_nx    = owner;
                    drun_nx  = '0;
                    state_nx = S_IDLE;
                end else if (ramstate == RS_ERROR) begin
                    ram_err_nx = 1'b1;
                    state_nx   = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // The starvation run only counts while some core is actually waiting.
        if (!i_any) begin
            drun_nx = '0;
        end
    end

    // RAM and requester drives, purely from the registered grant and live requests.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        dload    = '0;
        iwait    = '1;
        iload    = '0;

        case (state)
            S_DGRANT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dWEN ? dstore : 32'h0;
                dload    = ramload;
                if (d_req && (ramstate == RS_ACCESS)) begin
                    dwait = 1'b0;
                end
            end

            S_IGRANT: begin
                ramaddr = iaddr_sel;
                // Gated by the request so a withdrawal drops the enable in the same cycle.
                ramREN  = i_req;
                for (int k = 0; k < CPUS; k++) begin
                    if (owner == OW'(k)) begin
                        iload[32*k +: 32] = ramload;
                        if (i_req && (ramstate == RS_ACCESS)) begin
                            iwait[k] = 1'b0;
                        end
                    end
                end
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose : self-checking bench for ram_arbiter (CPUS=2, DRUN_MAX=4).
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the RAM model is scripted per cycle through ramstate/ramload.
module tb_ram_arbiter;

    logic         CLK;
    logic         RST;
    logic         dREN, dWEN, dlock;
    logic [31:0]  daddr, dstore;
    logic         dwait;
    logic [31:0]  dload;
    logic [1:0]   iREN;
    logic [63:0]  iaddr;
    logic [1:0]   iwait;
    logic [63:0]  iload;
    logic         ramREN, ramWEN;
    logic [31:0]  ramaddr, ramstore;
    logic [31:0]  ramload;
    logic [1:0]   ramstate;
    logic         ram_err;

    ram_arbiter #(.CPUS(2), .DRUN_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        dREN = 1'b0; dWEN = 1'b0; dlock = 1'b0;
        daddr = 32'h0; dstore = 32'h0;
        iREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
    endtask

    typedef struct {
        logic        dren, dwen, dlock;
        logic [31:0] daddr, dstore;
        logic [1:0]  iren, rstate;
        logic [31:0] rload;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_dwait;
        logic [1:0]  e_iwait;
        logic [31:0] e_dload, e_il0, e_il1;
        logic        e_err;
    } vec_t;

    vec_t v [18];

    // Grant source codes in the scoreboard: 0/1 = icache core, 2 = data side.
    int exp_q[$];

    function automatic logic [31:0] addr_of(input int src);
        if (src == 2) return 32'h500;
        if (src == 0) return 32'h100;
        return 32'h180;
    endfunction

    initial begin
        int lows;
        int got;
        int e;
        int g;

        n_cmp = 0;
        n_bad = 0;

        // Single fetch from core 0: two BUSY cycles then ACCESS.
        v[0]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[1]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'd1,32'h1234,     1'b1,1'b0,32'h100,32'h0, 1'b1,2'b11,32'h0,   32'h1234,    32'h0,1'b0};
        v[2]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'd1,32'h1234,     1'b1,1'b0,32'h100,32'h0, 1'b1,2'b11,32'h0,   32'h1234,    32'h0,1'b0};
        v[3]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'd2,32'hDEADBEEF, 1'b1,1'b0,32'h100,32'h0, 1'b1,2'b10,32'h0,   32'hDEADBEEF,32'h0,1'b0};
        v[4]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b00,2'd0,32'hCAFE,     1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        // Write wins over read.
        v[5]  = '{1'b1,1'b1,1'b0,32'h300,32'h55,2'b00,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[6]  = '{1'b1,1'b1,1'b0,32'h300,32'h55,2'b00,2'd2,32'h77,       1'b0,1'b1,32'h300,32'h55,1'b0,2'b11,32'h77,  32'h0,       32'h0,1'b0};
        v[7]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b00,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        // Locked write pair with a pending fetch, then the fetch, which is withdrawn.
        v[8]  = '{1'b0,1'b1,1'b1,32'h200,32'h11,2'b01,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[9]  = '{1'b0,1'b1,1'b1,32'h200,32'h11,2'b01,2'd2,32'hA5A5,     1'b0,1'b1,32'h200,32'h11,1'b0,2'b11,32'hA5A5,32'h0,       32'h0,1'b0};
        v[10] = '{1'b0,1'b1,1'b0,32'h204,32'h22,2'b01,2'd2,32'h5A5A,     1'b0,1'b1,32'h204,32'h22,1'b0,2'b11,32'h5A5A,32'h0,       32'h0,1'b0};
        v[11] = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[12] = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'd1,32'h0,        1'b1,1'b0,32'h100,32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[13] = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b00,2'd1,32'h0,        1'b0,1'b0,32'h100,32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[14] = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b00,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        // Data read answered with ERROR.
        v[15] = '{1'b1,1'b0,1'b0,32'h400,32'h0, 2'b00,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b0};
        v[16] = '{1'b1,1'b0,1'b0,32'h400,32'h0, 2'b00,2'd3,32'h99,       1'b1,1'b0,32'h400,32'h0, 1'b1,2'b11,32'h99,  32'h0,       32'h0,1'b0};
        v[17] = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 2'b00,2'd0,32'h0,        1'b0,1'b0,32'h0,  32'h0, 1'b1,2'b11,32'h0,   32'h0,       32'h0,1'b1};

        // Reset with every request active: outputs must still be quiet.
        RST = 1'b1;
        iaddr = {32'h180, 32'h100};
        dREN = 1'b1; dWEN = 1'b1; dlock = 1'b1;
        daddr = 32'h999; dstore = 32'h888;
        iREN = 2'b11; ramstate = 2'd2; ramload = 32'hFFFF_FFFF;
        #12;
        chk("rst_ren",   32'(ramREN),   32'h0);
        chk("rst_wen",   32'(ramWEN),   32'h0);
        chk("rst_addr",  ramaddr,       32'h0);
        chk("rst_store", ramstore,      32'h0);
        chk("rst_dwait", 32'(dwait),    32'h1);
        chk("rst_iwait", 32'(iwait),    32'h3);
        chk("rst_dload", dload,         32'h0);
        chk("rst_il0",   iload[31:0],   32'h0);
        chk("rst_il1",   iload[63:32],  32'h0);
        chk("rst_err",   32'(ram_err),  32'h0);
        drive_idle();
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(posedge CLK);
            #1;
            dREN = v[i].dren; dWEN = v[i].dwen; dlock = v[i].dlock;
            daddr = v[i].daddr; dstore = v[i].dstore;
            iREN = v[i].iren; ramstate = v[i].rstate; ramload = v[i].rload;
            @(negedge CLK);
            chk($sformatf("v%0d_ren", i),   32'(ramREN),  32'(v[i].e_ren));
            chk($sformatf("v%0d_wen", i),   32'(ramWEN),  32'(v[i].e_wen));
            chk($sformatf("v%0d_addr", i),  ramaddr,      v[i].e_addr);
            chk($sformatf("v%0d_store", i), ramstore,     v[i].e_store);
            chk($sformatf("v%0d_dwait", i), 32'(dwait),   32'(v[i].e_dwait));
            chk($sformatf("v%0d_iwait", i), 32'(iwait),   32'(v[i].e_iwait));
            chk($sformatf("v%0d_dload", i), dload,        v[i].e_dload);
            chk($sformatf("v%0d_il0", i),   iload[31:0],  v[i].e_il0);
            chk($sformatf("v%0d_il1", i),   iload[63:32], v[i].e_il1);
            chk($sformatf("v%0d_err", i),   32'(ram_err), 32'(v[i].e_err));
        end

        // Error flag is sticky until reset.
        @(posedge CLK);
        #1 drive_idle();
        @(negedge CLK);
        chk("err_sticky", 32'(ram_err), 32'h1);
        RST = 1'b1;
        #2;
        chk("err_cleared", 32'(ram_err), 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Priority + round-robin: everything held, RAM answers ACCESS every cycle.
        @(posedge CLK);
        #1;
        dREN = 1'b1; daddr = 32'h500;
        iREN = 2'b11; ramstate = 2'd2; ramload = 32'h4242;
        exp_q = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 1};
        g = 0;
        for (int c = 0; c < 40; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
            lows = 0;
            if (!dwait)    lows++;
            if (!iwait[0]) lows++;
            if (!iwait[1]) lows++;
            if (lows != 0) begin
                chk($sformatf("g%0d_one_owner", g), 32'(lows), 32'h1);
                got = (!dwait) ? 2 : ((!iwait[0]) ? 0 : 1);
                e = exp_q.pop_front();
                chk($sformatf("g%0d_src", g),  32'(got), 32'(e));
                chk($sformatf("g%0d_addr", g), ramaddr,  addr_of(e));
                if (e == 2) begin
                    chk($sformatf("g%0d_dload", g), dload, 32'h4242);
                    chk($sformatf("g%0d_iload", g), iload[31:0] | iload[63:32], 32'h0);
                end else if (e == 0) begin
                    chk($sformatf("g%0d_il0", g), iload[31:0],  32'h4242);
                    chk($sformatf("g%0d_il1", g), iload[63:32], 32'h0);
                end else begin
                    chk($sformatf("g%0d_il1", g), iload[63:32], 32'h4242);
                    chk($sformatf("g%0d_il0", g), iload[31:0],  32'h0);
                end
                g++;
            end
        end
        chk("grant_timeout", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset in the middle of a data write grant.
        @(posedge CLK);
        #1 drive_idle();
        @(posedge CLK);
        #1;
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'h66; ramstate = 2'd1;
        @(posedge CLK);
        @(negedge CLK);
        chk("ar_pre_wen", 32'(ramWEN), 32'h1);
        #1 ramstate = 2'd2;
        #1 chk("ar_pre_dwait", 32'(dwait), 32'h0);
        #1 RST = 1'b1;
        #1;
        chk("ar_wen",   32'(ramWEN), 32'h0);
        chk("ar_dwait", 32'(dwait),  32'h1);
        chk("ar_store", ramstore,    32'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1 chk("ar_idle_wen", 32'(ramWEN), 32'h0);
        @(negedge CLK);
        chk("ar_regrant_wen",   32'(ramWEN), 32'h1);
        chk("ar_regrant_dwait", 32'(dwait),  32'h0);
        chk("ar_regrant_addr",  ramaddr,     32'h600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
